// File: rtl/bus_rr_sched_pkg.sv
// Shared definitions for the 4-master round-robin bus scheduler:
// owner index type, FSM state codes, default limits and the round-robin pick.
package bus_rr_sched_pkg;

  typedef logic [1:0] bus_owner_t;

  typedef enum logic [1:0] {
    BUS_SCHED_IDLE  = 2'd0,
    BUS_SCHED_GRANT = 2'd1,
    BUS_SCHED_TOUT  = 2'd2
  } bus_sched_state_e;

  localparam int BUS_TENURE_DEF = 16;
  localparam int BUS_TO_DEF     = 255;

  typedef struct packed {
    logic       found;
    bus_owner_t idx;
  } rr_pick_t;

  function automatic logic [3:0] owner_onehot(input bus_owner_t idx);
    return 4'b0001 << idx;
  endfunction

  // First requester scanning last+1, last+2, ... wrapping; last itself is checked last.
  function automatic rr_pick_t rr_pick(input logic [3:0] req, input bus_owner_t last);
    rr_pick_t   res;
    bus_owner_t cand;
    res.found = 1'b0;
    res.idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_rr_sched_if.sv
// Shared-bus handshake seen by the scheduler: active-low requests, grants,
// address strobe, slave ready and the forced timeout ready.
interface bus_rr_sched_if;

  logic m0_req_;
  logic m1_req_;
  logic m2_req_;
  logic m3_req_;
  logic m0_grnt_;
  logic m1_grnt_;
  logic m2_grnt_;
  logic m3_grnt_;
  logic s_as_;
  logic m_rdy_;
  logic to_rdy_;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_, s_as_, m_rdy_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, to_rdy_
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_, m_rdy_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, to_rdy_
  );

endinterface

// File: rtl/bus_rr_sched_timeout_mon.sv
// Bus-timeout monitor: counts cycles with s_as_ low and no m_rdy_, and flags
// the cycle in which the count reaches its limit. TO_CYCLES of 0 disables it.
module bus_timeout_mon
  import bus_rr_sched_pkg::*;
#(
  parameter int TO_CYCLES = BUS_TO_DEF,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic s_as_,
  input  logic m_rdy_,
  output logic to_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST = (TO_CYCLES == 0) ? '0 : CNT_W'(TO_CYCLES - 1);
  localparam logic             MON_EN  = (TO_CYCLES != 0);

  logic [CNT_W-1:0] to_cnt_q;
  logic [CNT_W-1:0] to_cnt_d;
  logic             busy_s;

  // Count stalled accesses; a ready in the limit cycle cancels the timeout.
  always_comb begin
    busy_s = enable && !s_as_ && m_rdy_;
    to_hit = MON_EN && busy_s && (to_cnt_q == TO_LAST);
    if (!busy_s || to_hit) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != CNT_MAX) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin arbiter for the 4-master shared bus with tenure-limited
// preemption and a slave timeout that forces a one-cycle ready plus error.
module bus_rr_sched
  import bus_rr_sched_pkg::*;
#(
  parameter int TENURE_MAX = BUS_TENURE_DEF,
  parameter int TO_CYCLES  = BUS_TO_DEF,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_rr_sched_if.slave        bus,
  input  logic                 err_clr,
  output logic                 bus_err,
  output logic [1:0]           err_master,
  output logic                 err_sticky,
  output bus_owner_t           owner,
  output logic                 owner_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TENURE_LAST = CNT_W'(TENURE_MAX - 1);

  bus_sched_state_e state_q, state_d;
  logic [3:0]       grnt_q, grnt_d;
  bus_owner_t       owner_q, owner_d;
  bus_owner_t       last_q, last_d;
  logic             owner_vld_q, owner_vld_d;
  logic [CNT_W-1:0] tenure_q, tenure_d;
  logic             to_rdy_q, to_rdy_d;
  logic             bus_err_q, bus_err_d;
  bus_owner_t       err_master_q, err_master_d;
  logic             err_sticky_q, err_sticky_d;

  logic [3:0]       req_s;
  logic [3:0]       others_s;
  rr_pick_t         pick_idle_s;
  rr_pick_t         pick_next_s;
  logic             tenure_exp_s;
  logic             to_hit_s;
  logic             do_grant_s;
  logic             do_idle_s;
  bus_owner_t       grant_idx_s;

  assign req_s = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

  bus_timeout_mon #(
    .TO_CYCLES (TO_CYCLES),
    .CNT_W     (CNT_W)
  ) u_to_mon (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == BUS_SCHED_GRANT),
    .s_as_  (bus.s_as_),
    .m_rdy_ (bus.m_rdy_),
    .to_hit (to_hit_s)
  );

  // Next-state logic: timeout beats release, release beats tenure preemption.
  always_comb begin
    others_s     = req_s & ~owner_onehot(owner_q);
    pick_idle_s  = rr_pick(req_s, last_q);
    pick_next_s  = rr_pick(others_s, owner_q);
    tenure_exp_s = (tenure_q >= TENURE_LAST);
    do_grant_s   = 1'b0;
    do_idle_s    = 1'b0;
    grant_idx_s  = owner_q;
    state_d      = state_q;
    tenure_d     = tenure_q;
    bus_err_d    = 1'b0;
    to_rdy_d     = 1'b1;
    err_master_d = err_master_q;

    case (state_q)
      BUS_SCHED_IDLE: begin
        if (pick_idle_s.found) begin
          do_grant_s  = 1'b1;
          grant_idx_s = pick_idle_s.idx;
        end else begin
          do_idle_s = 1'b1;
        end
      end
      BUS_SCHED_GRANT: begin
        if (to_hit_s) begin
          state_d      = BUS_SCHED_TOUT;
          bus_err_d    = 1'b1;
          to_rdy_d     = 1'b0;
          err_master_d = owner_q;
        end else if (!req_s[owner_q]) begin
          if (pick_next_s.found) begin
            do_grant_s  = 1'b1;
            grant_idx_s = pick_next_s.idx;
          end else begin
            do_idle_s = 1'b1;
          end
        end else if (tenure_exp_s && pick_next_s.found && bus.s_as_) begin
          // Scanning from the revoked owner puts it behind every other requester.
          do_grant_s  = 1'b1;
          grant_idx_s = pick_next_s.idx;
        end else if (|others_s) begin
          tenure_d = (tenure_q == CNT_MAX) ? tenure_q : tenure_q + CNT_W'(1);
        end else begin
          tenure_d = tenure_q;
        end
      end
      BUS_SCHED_TOUT: begin
        if (req_s[owner_q]) begin
          state_d = BUS_SCHED_GRANT;
        end else begin
          do_idle_s = 1'b1;
        end
      end
      default: begin
        do_idle_s = 1'b1;
      end
    endcase

    if (do_grant_s) begin
      state_d     = BUS_SCHED_GRANT;
      grnt_d      = ~owner_onehot(grant_idx_s);
      owner_d     = grant_idx_s;
      last_d      = grant_idx_s;
      owner_vld_d = 1'b1;
      tenure_d    = '0;
    end else if (do_idle_s) begin
      state_d     = BUS_SCHED_IDLE;
      grnt_d      = 4'hF;
      owner_d     = owner_q;
      last_d      = last_q;
      owner_vld_d = 1'b0;
      tenure_d    = '0;
    end else begin
      grnt_d      = grnt_q;
      owner_d     = owner_q;
      last_d      = last_q;
      owner_vld_d = owner_vld_q;
    end

    // Set wins over clear while the error pulse is being raised or shown.
    if (bus_err_d || bus_err_q) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BUS_SCHED_IDLE;
      grnt_q       <= 4'hF;
      owner_q      <= 2'd0;
      last_q       <= 2'd3;
      owner_vld_q  <= 1'b0;
      tenure_q     <= '0;
      to_rdy_q     <= 1'b1;
      bus_err_q    <= 1'b0;
      err_master_q <= 2'd0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grnt_q       <= grnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      owner_vld_q  <= owner_vld_d;
      tenure_q     <= tenure_d;
      to_rdy_q     <= to_rdy_d;
      bus_err_q    <= bus_err_d;
      err_master_q <= err_master_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.to_rdy_  = to_rdy_q;
  assign bus_err      = bus_err_q;
  assign err_master   = err_master_q;
  assign err_sticky   = err_sticky_q;
  assign owner        = owner_q;
  assign owner_vld    = owner_vld_q;

endmodule
